// File: rtl/mini_pkg.sv
// Shared definitions for the mini_* signature analyzer: FSM state encoding
// and the default datapath width / MISR feedback polynomial.
package mini_pkg;

   localparam int                     MINI_DATA_W = 4;
   // x^4 + x + 1 expressed as the taps XORed in when the MSB shifts out
   localparam logic [MINI_DATA_W-1:0] MINI_POLY   = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } state_e;

endpackage

// File: rtl/mini_sig_analyzer_if.sv
// Bus between the stimulus/response source (master) and the signature
// analyzer (slave).
//
// Handshake: in_valid has no matching ready. While the analyzer is in
// COLLECT every cycle with in_valid=1 transfers exactly one stim/resp pair;
// in IDLE and DONE in_valid is ignored. start is a single-cycle request that
// is honoured only in IDLE and DONE.
interface mini_sig_analyzer_if
   import mini_pkg::*;
#(
   parameter int DATA_W  = MINI_DATA_W,
   parameter int NUM_VEC = 16
);
   localparam int CNT_W = $clog2(NUM_VEC + 1);

   logic              start;
   logic              in_valid;
   logic [DATA_W-1:0] stim;
   logic [DATA_W-1:0] resp;
   logic              busy;
   logic              done;
   logic              pass;
   logic              seq_err;
   logic              timeout;
   logic [DATA_W-1:0] signature;
   logic [CNT_W-1:0]  vec_cnt;
   state_e            dbg_state;

   modport master (
      output start, in_valid, stim, resp,
      input  busy, done, pass, seq_err, timeout, signature, vec_cnt, dbg_state
   );

   modport slave (
      input  start, in_valid, stim, resp,
      output busy, done, pass, seq_err, timeout, signature, vec_cnt, dbg_state
   );

endinterface

// File: rtl/mini_misr.sv
// Single-input-per-cycle MISR: shift left, fold the outgoing MSB back through
// POLY, and XOR in the new response word.
module mini_misr
   import mini_pkg::*;
#(
   parameter int                DATA_W = MINI_DATA_W,
   parameter logic [DATA_W-1:0] POLY   = MINI_POLY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] seed,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] sig
);

   logic [DATA_W-1:0] r_sig;
   logic [DATA_W-1:0] w_sig_nxt;

   // next signature: truncated shift, feedback on MSB, then absorb din
   always_comb begin
      w_sig_nxt = (r_sig << 1) ^ (r_sig[DATA_W-1] ? POLY : '0) ^ din;
   end

   // signature register: reset clears, load takes the seed, en compacts
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sig <= '0;
      end else if (load) begin
         r_sig <= seed;
      end else if (en) begin
         r_sig <= w_sig_nxt;
      end
   end

   assign sig = r_sig;

endmodule

// File: rtl/mini_sig_analyzer.sv
// Response-side checker for the exhaustive stimulus flow: compacts DUT
// responses into a MISR, verifies stimuli arrive as 0,1,2,... and reports
// pass/fail against GOLDEN after NUM_VEC vectors.
// Optional feature macro: MINI_SIG_TIMEOUT_EN (idle watchdog of TIMEOUT
// cycles in COLLECT; when undefined, COLLECT waits indefinitely).
module mini_sig_analyzer
   import mini_pkg::*;
#(
   parameter int                DATA_W  = MINI_DATA_W,
   parameter int                NUM_VEC = 16,
   parameter logic [DATA_W-1:0] POLY    = MINI_POLY,
   parameter logic [DATA_W-1:0] SEED    = '0,
   parameter logic [DATA_W-1:0] GOLDEN  = '0,
   parameter int                TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst,
   mini_sig_analyzer_if.slave bus
);

   localparam int CNT_W = $clog2(NUM_VEC + 1);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [DATA_W-1:0] r_exp;
   logic [CNT_W-1:0]  r_vec_cnt;
   logic              r_seq_err;
   logic              r_timeout;
   logic              w_start_run;
   logic              w_accept;
   logic              w_last;
   logic              w_to_fire;
   logic [DATA_W-1:0] w_sig;

   assign w_start_run = bus.start && (r_state != ST_COLLECT);
   assign w_accept    = (r_state == ST_COLLECT) && bus.in_valid;
   assign w_last      = w_accept && (r_vec_cnt == CNT_W'(NUM_VEC - 1));

`ifdef MINI_SIG_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   logic [IDLE_W-1:0] r_idle_cnt;

   // idle watchdog: counts consecutive COLLECT cycles without a vector
   always_ff @(posedge clk) begin
      if (rst || w_start_run || w_accept) begin
         r_idle_cnt <= '0;
      end else if (r_state == ST_COLLECT) begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   // fires on the edge where the idle count would reach TIMEOUT
   assign w_to_fire = (r_state == ST_COLLECT) && !bus.in_valid &&
                      (r_idle_cnt == IDLE_W'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);
   assign w_to_fire        = 1'b0;
`endif

   // FSM next-state: start only from IDLE/DONE, leave COLLECT on last vector
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:    if (bus.start) w_state_nxt = ST_COLLECT;
         ST_COLLECT: if (w_last || w_to_fire) w_state_nxt = ST_DONE;
         ST_DONE:    if (bus.start) w_state_nxt = ST_COLLECT;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // run bookkeeping: expected index, vector count and sticky error flags
   always_ff @(posedge clk) begin
      if (rst || w_start_run) begin
         r_exp     <= '0;
         r_vec_cnt <= '0;
         r_seq_err <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_exp     <= r_exp + 1'b1;
            r_vec_cnt <= r_vec_cnt + 1'b1;
            if (bus.stim != r_exp) r_seq_err <= 1'b1;
         end
         if (w_to_fire) r_timeout <= 1'b1;
      end
   end

   mini_misr #(
      .DATA_W (DATA_W),
      .POLY   (POLY)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (w_start_run),
      .seed (SEED),
      .en   (w_accept),
      .din  (bus.resp),
      .sig  (w_sig)
   );

   // pass is a decode of registers that all settle on the edge entering
   // DONE and then hold, so it changes in the same cycle as done
   assign bus.busy      = (r_state == ST_COLLECT);
   assign bus.done      = (r_state == ST_DONE);
   assign bus.pass      = (r_state == ST_DONE) && (w_sig == GOLDEN) &&
                          !r_seq_err && !r_timeout;
   assign bus.seq_err   = r_seq_err;
   assign bus.timeout   = r_timeout;
   assign bus.signature = w_sig;
   assign bus.vec_cnt   = r_vec_cnt;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mini_sig_analyzer.sv
// Directed bench for mini_sig_analyzer. Three instances share one stimulus
// stream: A (NUM_VEC=4, GOLDEN=2), B (NUM_VEC=4, GOLDEN=5) and
// C (NUM_VEC=2, GOLDEN=3); all use POLY=0011, SEED=0, TIMEOUT=8.
module tb_mini_sig_analyzer;
   import mini_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [3:0] stim;
   logic [3:0] resp;

   int n_checks;
   int n_errors;
   logic [3:0] exp_q[$];
   logic       watch_done;
   logic       saw_done;

   mini_sig_analyzer_if #(.DATA_W(4), .NUM_VEC(4)) if_a ();
   mini_sig_analyzer_if #(.DATA_W(4), .NUM_VEC(4)) if_b ();
   mini_sig_analyzer_if #(.DATA_W(4), .NUM_VEC(2)) if_c ();

   assign if_a.start = start;  assign if_a.in_valid = in_valid;
   assign if_a.stim  = stim;   assign if_a.resp     = resp;
   assign if_b.start = start;  assign if_b.in_valid = in_valid;
   assign if_b.stim  = stim;   assign if_b.resp     = resp;
   assign if_c.start = start;  assign if_c.in_valid = in_valid;
   assign if_c.stim  = stim;   assign if_c.resp     = resp;

   mini_sig_analyzer #(.DATA_W(4), .NUM_VEC(4), .POLY(4'b0011), .SEED(4'h0),
                       .GOLDEN(4'h2), .TIMEOUT(8))
      u_a (.clk(clk), .rst(rst), .bus(if_a));
   mini_sig_analyzer #(.DATA_W(4), .NUM_VEC(4), .POLY(4'b0011), .SEED(4'h0),
                       .GOLDEN(4'h5), .TIMEOUT(8))
      u_b (.clk(clk), .rst(rst), .bus(if_b));
   mini_sig_analyzer #(.DATA_W(4), .NUM_VEC(2), .POLY(4'b0011), .SEED(4'h0),
                       .GOLDEN(4'h3), .TIMEOUT(8))
      u_c (.clk(clk), .rst(rst), .bus(if_c));

   // clock / global time bound
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL sim_time_limit got=running exp=finished");
      $fatal(1, "time limit");
   end

   // records any done seen on instance A while watching a restarted run
   always @(posedge clk) begin
      if (watch_done && if_a.done) saw_done <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; stim = '0; resp = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_vec(input logic [3:0] s, input logic [3:0] r);
      in_valid = 1'b1; stim = s; resp = r;
      step();
      in_valid = 1'b0;
   endtask

   // send one vector and compare A's signature with the scoreboard head
   task automatic send_chk(input string tag, input logic [3:0] s,
                           input logic [3:0] r);
      logic [3:0] e;
      send_vec(s, r);
      if (exp_q.size() == 0) begin
         check({tag, "_q_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check(tag, if_a.signature, e);
      end
   endtask

   task automatic load_basic_exp();
      exp_q.delete();
      exp_q.push_back(4'h1); exp_q.push_back(4'h0);
      exp_q.push_back(4'h3); exp_q.push_back(4'h2);
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      watch_done = 1'b0; saw_done = 1'b0;
      do_reset();

      // reset state
      check("rst_busy",  if_a.busy,      0);
      check("rst_done",  if_a.done,      0);
      check("rst_pass",  if_a.pass,      0);
      check("rst_seq",   if_a.seq_err,   0);
      check("rst_to",    if_a.timeout,   0);
      check("rst_sig",   if_a.signature, 0);
      check("rst_cnt",   if_a.vec_cnt,   0);
      check("rst_state", if_a.dbg_state, ST_IDLE);

      // in_valid ignored in IDLE
      send_vec(4'h0, 4'h5);
      check("idle_cnt", if_a.vec_cnt,   0);
      check("idle_sig", if_a.signature, 0);

      // basic run: resp 1,2,3,4 -> signature 1,0,3,2
      do_start();
      check("start_busy", if_a.busy, 1);
      load_basic_exp();
      send_chk("b_sig0", 4'h0, 4'h1);
      send_chk("b_sig1", 4'h1, 4'h2);
      send_chk("b_sig2", 4'h2, 4'h3);
      check("b_done_early", if_a.done, 0);
      send_chk("b_sig3", 4'h3, 4'h4);
      check("b_done",   if_a.done,    1);
      check("b_busy",   if_a.busy,    0);
      check("b_pass",   if_a.pass,    1);
      check("b_cnt",    if_a.vec_cnt, 4);
      check("g5_done",  if_b.done,    1);
      check("g5_pass",  if_b.pass,    0);
      check("g5_seq",   if_b.seq_err, 0);

      // in_valid ignored in DONE
      send_vec(4'h4, 4'h7);
      check("dn_sig",  if_a.signature, 2);
      check("dn_cnt",  if_a.vec_cnt,   4);
      check("dn_done", if_a.done,      1);

      // restart from DONE with in_valid on the start cycle: not accepted
      start = 1'b1; in_valid = 1'b1; stim = 4'h0; resp = 4'h5;
      step();
      start = 1'b0; in_valid = 1'b0;
      check("rs_busy", if_a.busy,      1);
      check("rs_done", if_a.done,      0);
      check("rs_cnt",  if_a.vec_cnt,   0);
      check("rs_sig",  if_a.signature, 0);

      // sequence error: stim 0,1,3,3 with the same responses
      load_basic_exp();
      send_chk("se_sig0", 4'h0, 4'h1);
      send_chk("se_sig1", 4'h1, 4'h2);
      check("se_seq_ok", if_a.seq_err, 0);
      send_chk("se_sig2", 4'h3, 4'h3);
      check("se_seq", if_a.seq_err, 1);
      send_chk("se_sig3", 4'h3, 4'h4);
      check("se_done", if_a.done, 1);
      check("se_pass", if_a.pass, 0);

      // gaps of 3 idle cycles; a start mid-run is ignored
      do_start();
      check("gp_seq_clr", if_a.seq_err, 0);
      load_basic_exp();
      send_chk("gp_sig0", 4'h0, 4'h1); idle(3);
      send_chk("gp_sig1", 4'h1, 4'h2); idle(3);
      do_start();
      check("gp_start_ign", if_a.vec_cnt, 2);
      send_chk("gp_sig2", 4'h2, 4'h3); idle(3);
      send_chk("gp_sig3", 4'h3, 4'h4);
      check("gp_done", if_a.done,    1);
      check("gp_pass", if_a.pass,    1);
      check("gp_cnt",  if_a.vec_cnt, 4);

      // feedback on the 2-vector instance: resp 8 then 0 -> 8 then 3
      do_start();
      send_vec(4'h0, 4'h8);
      check("fb_sig0", if_c.signature, 8);
      send_vec(4'h1, 4'h0);
      check("fb_sig1", if_c.signature, 3);
      check("fb_done", if_c.done,      1);
      check("fb_pass", if_c.pass,      1);
      check("fb_cnt",  if_c.vec_cnt,   2);
      check("fb_a_busy", if_a.busy,    1);

      // reset mid-run on A (2 vectors in), then restart: no done pulse
      watch_done = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mr_busy",  if_a.busy,      0);
      check("mr_sig",   if_a.signature, 0);
      check("mr_cnt",   if_a.vec_cnt,   0);
      check("mr_state", if_a.dbg_state, ST_IDLE);
      do_start();
      check("mr2_cnt",  if_a.vec_cnt,   0);
      check("mr2_sig",  if_a.signature, 0);
      check("mr2_busy", if_a.busy,      1);
      check("mr_no_done", saw_done,     0);
      watch_done = 1'b0;

      // watchdog: two vectors then silence
      send_vec(4'h0, 4'h1);
      send_vec(4'h1, 4'h2);
      idle(7);
      check("to_pre_busy", if_a.busy,    1);
      check("to_pre_to",   if_a.timeout, 0);
      step();
`ifdef MINI_SIG_TIMEOUT_EN
      check("to_to",   if_a.timeout, 1);
      check("to_done", if_a.done,    1);
      check("to_pass", if_a.pass,    0);
      check("to_busy", if_a.busy,    0);
`else
      check("nto_busy", if_a.busy,    1);
      check("nto_to",   if_a.timeout, 0);
      check("nto_done", if_a.done,    0);
      idle(40);
      check("nto_busy_long", if_a.busy,    1);
      check("nto_to_long",   if_a.timeout, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mini_sig_analyzer.md
Name: mini_sig_analyzer

Overview:
- Response end of the exhaustive 4-bit stimulus flow used for the mini_* combinational blocks.
- Accepts one stimulus/response pair per valid cycle and checks that stimuli arrive in strict incrementing order.
- Compacts the responses into a MISR signature and reports pass/fail against a golden signature after NUM_VEC vectors.
- Sits alongside the mini_* DUT: stimulus source drives DUT input and this block; DUT output drives resp.

Parameters:
- DATA_W, 4, width of stimulus, response and signature.
- NUM_VEC, 16, number of vectors per run (>=1).
- POLY, 4'b0011, MISR feedback taps (x^4+x+1); width DATA_W.
- SEED, 4'b0000, signature value loaded at start.
- GOLDEN, 4'b0000, expected final signature.
- TIMEOUT, 64, idle-cycle limit; used only with MINI_SIG_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured in IDLE and DONE only.
- in_valid  in  1  stim/resp valid this cycle.
- stim  in  DATA_W  stimulus applied to the DUT.
- resp  in  DATA_W  DUT output for stim.
- busy  out  1  high in COLLECT.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid while done=1.
- seq_err  out  1  sticky; stim differed from the expected index.
- timeout  out  1  sticky; watchdog fired.
- signature  out  DATA_W  current MISR value.
- vec_cnt  out  $clog2(NUM_VEC+1)  vectors accepted this run.

Behaviour:
- Reset: when rst=1 at a clock edge, state=IDLE and all outputs are 0, including signature. Reset dominates start and in_valid. A reset during COLLECT aborts the run with no done pulse.
- FSM has three states: IDLE, COLLECT, DONE.
- IDLE -> COLLECT on start:
  - load signature<=SEED and vec_cnt<=0;
  - clear seq_err and timeout;
  - set expected index exp<=0.
- COLLECT, on a cycle with in_valid=1:
  - sig_next = (sig<<1 truncated to DATA_W) ^ (sig[DATA_W-1] ? POLY : 0) ^ resp;
  - if stim != exp, set seq_err=1 (sticky);
  - exp and vec_cnt increment; exp wraps modulo 2^DATA_W.
- COLLECT, on a cycle with in_valid=0: all state holds.
- COLLECT -> DONE on the edge that accepts vector number NUM_VEC. done rises 1 cycle after that last vector is accepted.
- pass = done & (signature==GOLDEN) & ~seq_err & ~timeout, registered together with done.
- Ignored inputs:
  - in_valid is ignored in IDLE and DONE;
  - start is ignored in COLLECT.
- DONE -> COLLECT on start, with the same initialisation as from IDLE. An in_valid on the same cycle as start is not accepted.
- Latency: signature reflects a vector 1 cycle after it is accepted.

Optional Feature:
- Macro: MINI_SIG_TIMEOUT_EN.
- Defined:
  - an idle counter clears on each accepted vector and increments on COLLECT cycles with in_valid=0;
  - when it reaches TIMEOUT: timeout=1, go to DONE, pass=0.
- Undefined: no counter is built, timeout is tied 0, and COLLECT waits indefinitely.

Decomposition:
- Shared package mini_pkg holds:
  - state encoding (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2);
  - DATA_W default and default POLY constant.
- One sub-module, mini_misr: DATA_W/POLY parameters; ports clk, rst, load, seed, en, din, sig.
- FSM, counters and compare stay in mini_sig_analyzer.

Test Plan:
- NUM_VEC=4, POLY=0011, SEED=0, GOLDEN=2; stim 0..3 with resp 1,2,3,4 on consecutive cycles -> signature 1,0,3,2; done=1 one cycle after the 4th vector; pass=1; vec_cnt=4.
- Same run with GOLDEN=5 -> done=1, pass=0, seq_err=0.
- Feedback check, NUM_VEC=2: resp 8 then 0 -> signature 8 then 3.
- Sequence error: stim 0,1,3,3 -> seq_err=1 after the 3rd vector; pass=0 even when the signature matches GOLDEN.
- in_valid gaps of 3 cycles between vectors give an identical signature; asserting rst mid-run, then start -> vec_cnt=0, signature=SEED, no done pulse.
- With MINI_SIG_TIMEOUT_EN and TIMEOUT=8: 2 vectors, then in_valid=0 -> timeout=1 and done=1 after 8 idle cycles, pass=0.
- Without MINI_SIG_TIMEOUT_EN: the same stimulus leaves busy=1 and timeout=0 indefinitely.
